// File: rtl/csd_seq_mult.sv
// Sequential multiplier: signed sample times a CSD coefficient, one digit per clock.
// Optional macro CSD_EARLY_EXIT_EN ends the run once no nonzero digits remain above idx.
module csd_seq_mult #(
  parameter int WIDTH  = 4,
  parameter int CWIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start,
  input  logic [WIDTH-1:0]        din,
  input  logic [CWIDTH-1:0]       coef_p,
  input  logic [CWIDTH-1:0]       coef_n,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH+CWIDTH:0]   dout,
  output logic                    err
);

  localparam int PW = WIDTH + CWIDTH + 1;
  localparam int IW = (CWIDTH > 1) ? $clog2(CWIDTH) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic signed [PW-1:0]    acc_q, acc_d;
  logic signed [WIDTH-1:0] din_q, din_d;
  logic [CWIDTH-1:0]       cp_q, cp_d;
  logic [CWIDTH-1:0]       cn_q, cn_d;
  logic                    conf_q, conf_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic signed [PW-1:0]    dout_q, dout_d;
  logic                    err_q, err_d;

  logic                    pos, neg, last, conf_nx;
  logic signed [PW-1:0]    term, acc_nx;

  // Sign-extend to the full product width first so the shift can never lose the sign.
  function automatic logic signed [PW-1:0] shift_sext(input logic signed [WIDTH-1:0] d,
                                                      input logic [IW-1:0] k);
    logic signed [PW-1:0] ext;
    ext = {{(PW-WIDTH){d[WIDTH-1]}}, d};
    return ext <<< k;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    din_d   = din_q;
    cp_d    = cp_q;
    cn_d    = cn_q;
    conf_d  = conf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    err_d   = err_q;

    // Digit step: a digit with both masks set counts as zero and flags a conflict.
    pos     = cp_q[idx_q];
    neg     = cn_q[idx_q];
    term    = shift_sext(din_q, idx_q);
    acc_nx  = acc_q;
    if (pos && !neg)
      acc_nx = acc_q + term;
    else if (neg && !pos)
      acc_nx = acc_q - term;
    conf_nx = conf_q | (pos & neg);
    last    = (idx_q == IW'(CWIDTH - 1));
`ifdef CSD_EARLY_EXIT_EN
    last    = last | ((((cp_q | cn_q) >> idx_q) >> 1) == '0);
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          din_d   = din;
          cp_d    = coef_p;
          cn_d    = coef_n;
          acc_d   = '0;
          idx_d   = '0;
          conf_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d  = acc_nx;
        conf_d = conf_nx;
        if (last) begin
          dout_d  = acc_nx;
          err_d   = conf_nx;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      din_q   <= '0;
      cp_q    <= '0;
      cn_q    <= '0;
      conf_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      din_q   <= din_d;
      cp_q    <= cp_d;
      cn_q    <= cn_d;
      conf_q  <= conf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dout = dout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_csd_seq_mult.sv
// Scoreboard bench for csd_seq_mult (WIDTH=4, CWIDTH=8): directed vectors,
// expectations queued at issue time and checked by an independent done monitor.
module tb_csd_seq_mult;

  logic               CLK;
  logic               RST;
  logic               start;
  logic signed [3:0]  din;
  logic [7:0]         coef_p;
  logic [7:0]         coef_n;
  logic               busy;
  logic               done;
  logic signed [12:0] dout;
  logic               err;

  csd_seq_mult #(.WIDTH(4), .CWIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .start(start), .din(din),
    .coef_p(coef_p), .coef_n(coef_n),
    .busy(busy), .done(done), .dout(dout), .err(err)
  );

  typedef struct {
    int v;
    int e;
    int c;
    string name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  function automatic int lat_of(input logic [7:0] p, input logic [7:0] n);
`ifdef CSD_EARLY_EXIT_EN
    int h = 0;
    for (int k = 0; k < 8; k++) if (p[k] | n[k]) h = k;
    return h + 1;
`else
    return 8;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk({x.name, "_dout"}, int'(dout), x.v);
        chk({x.name, "_err"}, int'(err), x.e);
        chk({x.name, "_cycle"}, cyc, x.c);
      end
    end
  end

  // Waits for idle, requests, then scrambles the inputs to prove operands are latched.
  task automatic issue(input string name, input logic signed [3:0] d,
                       input logic [7:0] p, input logic [7:0] n,
                       input int exp_v, input int exp_e);
    int w;
    exp_t x;
    w = 0;
    @(negedge CLK);
    while (busy && w < 100) begin
      @(negedge CLK);
      w++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout: got busy=1, expected busy=0", name);
    end
    start = 1'b1; din = d; coef_p = p; coef_n = n;
    @(posedge CLK);
    #1;
    x.v = exp_v; x.e = exp_e; x.c = cyc + lat_of(p, n); x.name = name;
    sb.push_back(x);
    start = 1'b0; din = 4'sd6; coef_p = ~p; coef_n = ~n;
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge CLK);
      w++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: got %0d pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int p;
    RST = 1'b1; start = 1'b0; din = '0; coef_p = '0; coef_n = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_err", int'(err), 0);

    issue("basic", 4'sd3, 8'h05, 8'h00, 15, 0);
    issue("neg_operand", -4'sd8, 8'h80, 8'h01, -1016, 0);
    issue("conflict", 4'sd5, 8'h11, 8'h01, 80, 1);
    issue("clean_after_conflict", -4'sd3, 8'h0A, 8'h20, 66, 0);
    issue("all_neg_digits", -4'sd8, 8'h00, 8'hFF, 2040, 0);
    issue("early_exit", 4'sd7, 8'h02, 8'h00, 14, 0);
    issue("zero_coef", 4'sd5, 8'h00, 8'h00, 0, 0);
    drain("directed");

    // Back-to-back with start held: din is disturbed mid-run and restored before each accept.
    p = lat_of(8'h01, 8'h00) + 1;
    @(negedge CLK);
    start = 1'b1; din = 4'sd1; coef_p = 8'h01; coef_n = 8'h00;
    for (int i = 0; i < 3; i++) begin
      exp_t x;
      @(posedge CLK);
      #1;
      x.v = 1; x.e = 0; x.c = cyc + p - 1; x.name = "back_to_back";
      sb.push_back(x);
      din = -4'sd5;
      repeat (p - 1) @(posedge CLK);
      #1 din = 4'sd1;
    end
    start = 1'b0;
    drain("back_to_back");

    // Abort mid-run: reset lands on the fourth edge after acceptance.
    issue("aborted", 4'sd3, 8'hFF, 8'h00, 765, 0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    sb.delete();
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_dout", int'(dout), 0);
    chk("abort_err", int'(err), 0);
    repeat (12) @(negedge CLK);
    issue("after_abort", -4'sd1, 8'h80, 8'h00, -128, 0);
    drain("after_abort");

    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
